// File: rtl/dmem_mmio_responder_if.sv
// Core-to-data-memory bus: load/store request from the core, load result,
// stall and misalignment status back from the responder.
//   master (core):      drives MemRead, MemWrite, addr, funct3, wdata
//   slave  (responder): drives rdata, stall, misalign
interface dmem_mmio_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] addr;
  logic [2:0]  funct3;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        misalign;

  modport master (
    output MemRead, MemWrite, addr, funct3, wdata,
    input  rdata, stall, misalign
  );

  modport slave (
    input  MemRead, MemWrite, addr, funct3, wdata,
    output rdata, stall, misalign
  );
endinterface

// File: rtl/dmem_mmio_responder.sv
// Data-side memory responder: byte/half/word loads and stores to a
// word-organised RAM or a small MMIO window (LED register, switches).
// Loads stall the core for READ_LATENCY cycles; misaligned requests are
// dropped and flagged with a one-cycle misalign pulse.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : core request/response bus (slave side)
//   switch_in  : board switches, readable at MMIO offset 0x04
//   led_out    : registered LED register at MMIO offset 0x00
module dmem_mmio_responder #(
  parameter int unsigned ADDR_WIDTH   = 14,
  parameter int unsigned READ_LATENCY = 2,
  parameter logic [31:0] MMIO_BASE    = 32'hFFFF_FC00
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_mmio_responder_if.slave  bus,
  input  logic [15:0]           switch_in,
  output logic [15:0]           led_out
);

  localparam int unsigned CNT_W = 3;
  localparam int unsigned DEPTH = 32'(1) << ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        rdata_q;
  logic               misalign_q;
  logic [15:0]        led_q;
  logic [31:0]        mem_q [DEPTH];

  // Request decode
  logic                  is_byte_c, is_half_c, is_word_c, aligned_c, is_mmio_c;
  logic [29:0]           mmio_word_c;
  logic [ADDR_WIDTH-1:0] ram_idx_c;
  logic                  store_go_c, load_go_c, misalign_go_c;
  logic [3:0]            be_c;
  logic [31:0]           wlane_c;

  always_comb begin
    is_byte_c   = (bus.funct3[1:0] == 2'b00);
    is_half_c   = (bus.funct3[1:0] == 2'b01);
    is_word_c   = !is_byte_c && !is_half_c;
    aligned_c   = is_byte_c ||
                  (is_half_c && !bus.addr[0]) ||
                  (is_word_c && (bus.addr[1:0] == 2'b00));
    is_mmio_c   = (bus.addr >= MMIO_BASE);
    mmio_word_c = 30'((bus.addr - MMIO_BASE) >> 2);
    ram_idx_c   = bus.addr[ADDR_WIDTH+1:2];

    // A simultaneous read+write is treated as a store only
    store_go_c    = (state_q == S_IDLE) && bus.MemWrite && aligned_c;
    load_go_c     = (state_q == S_IDLE) && bus.MemRead && !bus.MemWrite && aligned_c;
    misalign_go_c = (state_q == S_IDLE) && (bus.MemRead || bus.MemWrite) && !aligned_c;

    // Byte enables and lane-replicated store data
    if (is_byte_c) begin
      be_c    = 4'b0001 << bus.addr[1:0];
      wlane_c = {4{bus.wdata[7:0]}};
    end else if (is_half_c) begin
      be_c    = bus.addr[1] ? 4'b1100 : 4'b0011;
      wlane_c = {2{bus.wdata[15:0]}};
    end else begin
      be_c    = 4'b1111;
      wlane_c = bus.wdata;
    end
  end

  // Load data path: select source word, then size/sign extension
  logic [31:0] rword_c, rext_c;
  logic [7:0]  rbyte_c;
  logic [15:0] rhalf_c;

  always_comb begin
    if (is_mmio_c) begin
      if (mmio_word_c == 30'd0)      rword_c = {16'b0, led_q};
      else if (mmio_word_c == 30'd1) rword_c = {16'b0, switch_in};
      else                           rword_c = 32'b0;
    end else begin
      rword_c = mem_q[ram_idx_c];
    end
    rbyte_c = 8'(rword_c >> {bus.addr[1:0], 3'b000});
    rhalf_c = bus.addr[1] ? rword_c[31:16] : rword_c[15:0];
    if (is_byte_c)
      rext_c = bus.funct3[2] ? {24'b0, rbyte_c} : {{24{rbyte_c[7]}}, rbyte_c};
    else if (is_half_c)
      rext_c = bus.funct3[2] ? {16'b0, rhalf_c} : {{16{rhalf_c[15]}}, rhalf_c};
    else
      rext_c = rword_c;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state: WAIT lasts READ_LATENCY-1 cycles, so the request cycle
  // plus WAIT gives exactly READ_LATENCY stalled cycles before RESP
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (load_go_c) begin
          cnt_d = CNT_W'(READ_LATENCY - 1);
          if (READ_LATENCY == 1) state_d = S_RESP;
          else                   state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: stall is needed combinationally in the request cycle
  logic stall_c, ram_we_c, led_we_c;

  always_comb begin
    stall_c  = load_go_c || (state_q == S_WAIT);
    ram_we_c = store_go_c && !is_mmio_c && !rst;
    led_we_c = store_go_c && is_mmio_c && (mmio_word_c == 30'd0) && !rst;
  end

  // RAM: byte-enabled write, contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) mem_q[ram_idx_c][8*i +: 8] <= wlane_c[8*i +: 8];
      end
    end
  end

  // LED register, misalign pulse and load result.
  // The core holds the load request stable while stalled, so the live
  // address is still valid on the edge that enters RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q      <= '0;
      misalign_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (led_we_c) begin
        if (be_c[0]) led_q[7:0]  <= wlane_c[7:0];
        if (be_c[1]) led_q[15:8] <= wlane_c[15:8];
      end
      misalign_q <= misalign_go_c;
      if (state_d == S_RESP) rdata_q <= rext_c;
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.stall    = stall_c;
  assign bus.misalign = misalign_q;
  assign led_out      = led_q;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder (READ_LATENCY = 2).
module tb_dmem_mmio_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] switch_in;
  logic [15:0] led_out;
  int          checks   = 0;
  int          failures = 0;

  dmem_mmio_responder_if bus ();

  dmem_mmio_responder #(
    .ADDR_WIDTH   (14),
    .READ_LATENCY (2),
    .MMIO_BASE    (32'hFFFF_FC00)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .switch_in (switch_in),
    .led_out   (led_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
  endtask

  // One-cycle store; also_rd raises MemRead alongside MemWrite
  task automatic store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic also_rd);
    @(negedge clk);
    bus.MemWrite = 1'b1;
    bus.MemRead  = also_rd;
    bus.funct3   = f3;
    bus.addr     = a;
    bus.wdata    = d;
    #1 chk({tag, "_stall"}, 32'(bus.stall), 32'd0);
    @(posedge clk);
    #1 bus_idle();
  endtask

  // Load held until stall drops; returns in the RESP cycle
  task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    bus.MemRead  = 1'b1;
    bus.MemWrite = 1'b0;
    bus.funct3   = f3;
    bus.addr     = a;
    #1;
    while (bus.stall && n < 20) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk({tag, "_stallcyc"}, 32'(n), 32'd2);
    chk({tag, "_rdata"}, bus.rdata, exp);
    bus_idle();
  endtask

  // Misaligned request: no stall, misalign pulses for exactly one cycle
  task automatic misreq(input string tag, input logic rd, input logic [2:0] f3,
                        input logic [31:0] a);
    @(negedge clk);
    bus.MemRead  = rd;
    bus.MemWrite = !rd;
    bus.funct3   = f3;
    bus.addr     = a;
    bus.wdata    = 32'hDEAD_BEEF;
    #1 chk({tag, "_stall"}, 32'(bus.stall), 32'd0);
    @(posedge clk);
    #1 bus_idle();
    chk({tag, "_pulse"}, 32'(bus.misalign), 32'd1);
    @(posedge clk);
    #1 chk({tag, "_pulse_end"}, 32'(bus.misalign), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    switch_in = 16'h0000;
    bus_idle();
    bus.funct3 = 3'b010;
    bus.addr   = '0;
    bus.wdata  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_misalign", 32'(bus.misalign), 32'd0);
    chk("rst_led", 32'(led_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Word store/load, then byte store and sub-word loads
    store("sw10", 3'b010, 32'h10, 32'h1234_5678, 1'b0);
    load("lw10", 3'b010, 32'h10, 32'h1234_5678);
    store("sb13", 3'b000, 32'h13, 32'h0000_0080, 1'b0);
    load("lb13", 3'b000, 32'h13, 32'hFFFF_FF80);
    load("lbu13", 3'b100, 32'h13, 32'h0000_0080);
    load("lh12", 3'b001, 32'h12, 32'hFFFF_8034);
    load("lhu12", 3'b101, 32'h12, 32'h0000_8034);
    load("lb10", 3'b000, 32'h10, 32'h0000_0078);
    load("lh10", 3'b001, 32'h10, 32'h0000_5678);
    @(posedge clk);
    #1 chk("rdata_hold", bus.rdata, 32'h0000_5678);

    // Misaligned accesses leave memory and rdata alone
    store("sw00", 3'b010, 32'h00, 32'hCAFE_F00D, 1'b0);
    misreq("lw02", 1'b1, 3'b010, 32'h02);
    misreq("sh01", 1'b0, 3'b001, 32'h01);
    chk("mis_rdata", bus.rdata, 32'h0000_5678);
    load("lw00", 3'b010, 32'h00, 32'hCAFE_F00D);

    // MMIO: LEDs and switches
    switch_in = 16'hA5A5;
    store("led_sw", 3'b010, 32'hFFFF_FC00, 32'h0000_BEEF, 1'b0);
    chk("led_word", 32'(led_out), 32'h0000_BEEF);
    load("lw_sw", 3'b010, 32'hFFFF_FC04, 32'h0000_A5A5);
    load("lw_led", 3'b010, 32'hFFFF_FC00, 32'h0000_BEEF);
    store("led_sb1", 3'b000, 32'hFFFF_FC01, 32'h0000_0012, 1'b0);
    chk("led_byte", 32'(led_out), 32'h0000_12EF);
    store("mmio_other", 3'b010, 32'hFFFF_FC08, 32'h1111_1111, 1'b0);
    load("lw_other", 3'b010, 32'hFFFF_FC08, 32'h0000_0000);
    chk("led_kept", 32'(led_out), 32'h0000_12EF);

    // Reset in the WAIT cycle aborts the load
    @(negedge clk);
    bus.MemRead = 1'b1;
    bus.funct3  = 3'b010;
    bus.addr    = 32'h10;
    @(negedge clk);
    #1 chk("abort_wait_stall", 32'(bus.stall), 32'd1);
    rst = 1'b1;
    bus_idle();
    @(posedge clk);
    #1;
    chk("abort_stall", 32'(bus.stall), 32'd0);
    chk("abort_rdata", bus.rdata, 32'd0);
    chk("abort_led", 32'(led_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    load("lw_after_rst", 3'b010, 32'h10, 32'h8034_5678);

    // Simultaneous read+write behaves as a store
    store("rw20", 3'b010, 32'h20, 32'h0000_0055, 1'b1);
    load("lw20", 3'b010, 32'h20, 32'h0000_0055);

    // RAM index wraps modulo RAM size
    load("lw_wrap", 3'b010, 32'h0001_0010, 32'h8034_5678);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
